// File: rtl/dpwm_fc_pkg.sv
// Shared definitions for the dual-leg dead-time PWM modulator.
//   CNT_W       : width of the carrier counter (128-step carrier)
//   HALF_OFFSET : carrier offset applied to leg 2 (180-degree interleave)
//   leg_state_t : per-leg gate state machine encoding
package dpwm_fc_pkg;

  localparam int CNT_W       = 7;
  localparam int HALF_OFFSET = 64;

  typedef enum logic [1:0] {
    L_ON      = 2'd0,
    DEAD_TO_H = 2'd1,
    H_ON      = 2'd2,
    DEAD_TO_L = 2'd3
  } leg_state_t;

endpackage

// File: rtl/dpwm_fc_dt_leg.sv
// Dead-time gate state machine for one half-bridge leg.
// Ports:
//   clock   : system clock, rising edge
//   reset   : synchronous active-high reset
//   enable  : 0 forces gates off and parks the leg in DEAD_TO_L
//   raw     : un-deadtimed PWM request (1 = high side wanted)
//   gate_h  : registered high-side gate command (1 only in H_ON)
//   gate_l  : registered low-side gate command (1 only in L_ON)
// Parameter DT: dead time in clock cycles (1..255).
// The state register r_state is kept as a plain named register so that
// checkers can bind to it directly.
module dt_leg
  import dpwm_fc_pkg::*;
#(
  parameter int DT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic gate_h,
  output logic gate_l
);

  localparam logic [7:0] DT_M1 = 8'(DT - 1);

  leg_state_t r_state;
  logic [7:0] r_dcnt;

  // Entering a DEAD state always restarts the dead counter; the ON state is
  // reached at the DT-th edge spent in DEAD with raw still agreeing, so both
  // gates are low for exactly DT cycles. A raw reversal inside DEAD flips to
  // the opposite DEAD state, which is what swallows pulses shorter than DT.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      r_state <= DEAD_TO_L;
      r_dcnt  <= '0;
      gate_h  <= 1'b0;
      gate_l  <= 1'b0;
    end else begin
      case (r_state)
        L_ON: begin
          if (raw) begin
            r_state <= DEAD_TO_H;
            r_dcnt  <= '0;
            gate_l  <= 1'b0;
          end
        end
        H_ON: begin
          if (!raw) begin
            r_state <= DEAD_TO_L;
            r_dcnt  <= '0;
            gate_h  <= 1'b0;
          end
        end
        DEAD_TO_H: begin
          if (!raw) begin
            r_state <= DEAD_TO_L;
            r_dcnt  <= '0;
          end else if (r_dcnt == DT_M1) begin
            r_state <= H_ON;
            gate_h  <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 8'd1;
          end
        end
        default: begin // DEAD_TO_L
          if (raw) begin
            r_state <= DEAD_TO_H;
            r_dcnt  <= '0;
          end else if (r_dcnt == DT_M1) begin
            r_state <= L_ON;
            gate_l  <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dpwm_fc.sv
// Two-leg interleaved digital PWM with dead time and duty double-buffering.
// Ports:
//   clock, reset      : system clock / synchronous active-high reset
//   enable            : 1 = carrier runs; 0 = gates off, carrier parked at 0
//   duty_vld, D1, D2  : duty update strobe and 7-bit duty codes (1/128 units)
//   sample_trig       : one-cycle pulse in each period-start cycle
//   s1_h/s1_l/s2_h/s2_l : registered gate commands for leg 1 / leg 2
//   cnt               : current carrier count
//   stale             : previous period ran without a fresh duty update
// Parameters: PRESC (clocks per carrier count), DT (dead-time clocks).
//
// Duty handshake: duty_vld is a one-cycle strobe with no back-pressure; D1/D2
// are sampled on any enabled edge where duty_vld=1 into the pending pair, and
// the pending pair is copied to the active pair only at the edge that enters a
// period start. A strobe on that same edge lands in pending only.
//
// Period start is the cycle after an enabled edge that either wraps the
// carrier or is the first enabled edge after reset/disable (r_run=0).
module dpwm_fc
  import dpwm_fc_pkg::*;
#(
  parameter int PRESC = 4,
  parameter int DT    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             duty_vld,
  input  logic [CNT_W-1:0] D1,
  input  logic [CNT_W-1:0] D2,
  output logic             sample_trig,
  output logic             s1_h,
  output logic             s1_l,
  output logic             s2_h,
  output logic             s2_l,
  output logic [CNT_W-1:0] cnt,
  output logic             stale
);

  localparam logic [7:0] PRESC_M1 = 8'(PRESC - 1);

  logic [7:0]       r_presc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;    // carrier was running in the current cycle
  logic             r_trig;
  logic [CNT_W-1:0] r_pend1, r_pend2;
  logic [CNT_W-1:0] r_act1, r_act2;
  logic             r_seen;   // a strobe arrived since the last period start
  logic             r_stale;

  logic             w_tick;
  logic             w_wrap;
  logic             w_enter_ps;
  logic [CNT_W-1:0] w_cnt_sh;
  logic             w_raw1, w_raw2;

  assign w_tick     = (r_presc == PRESC_M1);
  assign w_wrap     = r_run && w_tick && (r_cnt == {CNT_W{1'b1}});
  assign w_enter_ps = enable && (!r_run || w_wrap);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_trig  <= 1'b0;
      r_pend1 <= '0;
      r_pend2 <= '0;
      r_act1  <= '0;
      r_act2  <= '0;
      r_seen  <= 1'b0;
      r_stale <= 1'b0;
    end else if (!enable) begin
      // Duty registers and stale deliberately hold across a disable.
      r_presc <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_trig  <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_trig <= w_enter_ps;
      // The first enabled edge keeps the carrier at 0 so the period-start
      // cycle shows cnt=0, prescaler=0.
      if (!r_run) begin
        r_presc <= '0;
        r_cnt   <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_presc <= r_presc + 8'd1;
      end

      if (duty_vld) begin
        r_pend1 <= D1;
        r_pend2 <= D2;
      end

      if (w_enter_ps) begin
        r_act1 <= r_pend1;
        r_act2 <= r_pend2;
        r_seen <= duty_vld;      // a strobe on this edge counts for the new period
        if (r_run) begin         // first period start after enable never flags
          r_stale <= !r_seen;
        end
      end else if (duty_vld) begin
        r_seen <= 1'b1;
      end
    end
  end

  // Leg 2 compares against the carrier shifted by half a period.
  assign w_cnt_sh = r_cnt + CNT_W'(HALF_OFFSET);
  assign w_raw1   = r_run && (r_cnt < r_act1);
  assign w_raw2   = r_run && (w_cnt_sh < r_act2);

  dt_leg #(.DT(DT)) u_leg1 (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .raw    (w_raw1),
    .gate_h (s1_h),
    .gate_l (s1_l)
  );

  dt_leg #(.DT(DT)) u_leg2 (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .raw    (w_raw2),
    .gate_h (s2_h),
    .gate_l (s2_l)
  );

  assign sample_trig = r_trig;
  assign cnt         = r_cnt;
  assign stale       = r_stale;

endmodule

// File: tb/tb_dpwm_fc.sv
// Directed self-checking bench for dpwm_fc (PRESC=4, DT=8, 512-clock period).
// Inputs change and outputs are sampled on the falling edge.
module tb_dpwm_fc;
  import dpwm_fc_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       duty_vld;
  logic [6:0] D1, D2;
  logic       sample_trig, s1_h, s1_l, s2_h, s2_l, stale;
  logic [6:0] cnt;

  int checks = 0;
  int errors = 0;

  int n, m_h1, m_d1, m_h2, m_d2, m_r1, m_r2, m_ov;

  dpwm_fc #(.PRESC(4), .DT(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .duty_vld    (duty_vld),
    .D1          (D1),
    .D2          (D2),
    .sample_trig (sample_trig),
    .s1_h        (s1_h),
    .s1_l        (s1_l),
    .s2_h        (s2_h),
    .s2_l        (s2_l),
    .cnt         (cnt),
    .stale       (stale)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; gate mutual exclusion is checked on every cycle.
  task automatic tick1();
    @(negedge clock);
    chk("mutex_leg1", {31'd0, s1_h & s1_l}, 32'd0);
    chk("mutex_leg2", {31'd0, s2_h & s2_l}, 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic strobe(input logic [6:0] d1v, input logic [6:0] d2v);
    duty_vld = 1'b1;
    D1       = d1v;
    D2       = d2v;
    tick1();
    duty_vld = 1'b0;
  endtask

  // Bounded wait for the next period start; returns cycles waited.
  task automatic wait_ps(output int cyc);
    cyc = 0;
    while (!sample_trig && cyc < 600) begin
      tick1();
      cyc++;
    end
    chk("ps_found", {31'd0, sample_trig}, 32'd1);
  endtask

  // Observe one full period starting in a period-start cycle: high-side
  // cycles, both-gates-off cycles, first rising index (-1 if none) per leg,
  // and high-side overlap between legs. Ends in the next period-start cycle.
  task automatic measure(output int h1, output int d1, output int h2, output int d2,
                         output int r1, output int r2, output int ov);
    logic p1, p2;
    h1 = 0; d1 = 0; h2 = 0; d2 = 0; r1 = -1; r2 = -1; ov = 0;
    p1 = s1_h;
    p2 = s2_h;
    for (int k = 0; k < 512; k++) begin
      if (s1_h) h1++;
      if (s2_h) h2++;
      if (!s1_h && !s1_l) d1++;
      if (!s2_h && !s2_l) d2++;
      if (s1_h && s2_h) ov++;
      if (k > 0 && s1_h && !p1 && r1 < 0) r1 = k;
      if (k > 0 && s2_h && !p2 && r2 < 0) r2 = k;
      p1 = s1_h;
      p2 = s2_h;
      tick1();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    duty_vld = 1'b0;
    D1       = '0;
    D2       = '0;
    repeat (3) tick1();
    chk("rst_cnt", cnt, 0);
    chk("rst_trig", sample_trig, 0);
    chk("rst_gates", {s1_h, s1_l, s2_h, s2_l}, 0);
    chk("rst_stale", stale, 0);

    // Start-up with no duty: period start on the first enabled edge.
    reset  = 1'b0;
    enable = 1'b1;
    tick1();                                   // k=0, PS1
    chk("ps1_trig", sample_trig, 1);
    chk("ps1_stale", stale, 0);
    chk("ps1_cnt", cnt, 0);
    chk("ps1_s1l", s1_l, 0);
    tick1();                                   // k=1
    chk("k1_trig", sample_trig, 0);
    repeat (5) tick1();                        // k=6
    chk("k6_s1l", s1_l, 0);
    chk("k6_cnt", cnt, 1);
    tick1();                                   // k=7
    chk("k7_s1l", s1_l, 1);
    chk("k7_s2l", s2_l, 1);
    chk("k7_s1h", s1_h, 0);
    wait_ps(n);                                // PS2
    chk("period_len", n, 505);
    chk("ps2_stale", stale, 1);
    measure(m_h1, m_d1, m_h2, m_d2, m_r1, m_r2, m_ov);
    chk("p2_h1", m_h1, 0);
    chk("p2_d1", m_d1, 0);
    chk("p2_h2", m_h2, 0);
    chk("p2_d2", m_d2, 0);

    // PS3: strobe 64/64 mid-period, applies from PS4.
    chk("ps3_stale", stale, 1);
    repeat (100) tick1();
    strobe(7'd64, 7'd64);
    wait_ps(n);                                // PS4
    chk("ps3_len", n, 411);
    chk("ps4_stale", stale, 0);
    measure(m_h1, m_d1, m_h2, m_d2, m_r1, m_r2, m_ov);
    chk("p4_h1", m_h1, 248);
    chk("p4_d1", m_d1, 16);
    chk("p4_r1", m_r1, 9);
    chk("p4_h2", m_h2, 247);
    chk("p4_d2", m_d2, 8);
    chk("p4_r2", m_r2, 265);
    chk("p4_ov", m_ov, 0);
    chk("ps5_stale", stale, 1);
    measure(m_h1, m_d1, m_h2, m_d2, m_r1, m_r2, m_ov);
    chk("p5_h1", m_h1, 248);
    chk("p5_d1", m_d1, 16);
    chk("p5_h2", m_h2, 248);
    chk("p5_d2", m_d2, 16);
    chk("p5_shift", m_r2 - m_r1, 256);
    chk("p5_ov", m_ov, 0);

    // PS6: D1=1 (shorter than dead time), D2=0.
    repeat (10) tick1();
    strobe(7'd1, 7'd0);
    wait_ps(n);                                // PS7
    chk("ps7_stale", stale, 0);
    measure(m_h1, m_d1, m_h2, m_d2, m_r1, m_r2, m_ov);
    chk("p7_h1", m_h1, 0);
    chk("p7_d1", m_d1, 12);
    chk("p7_r1", m_r1, -1);
    chk("p7_h2", m_h2, 1);
    chk("p7_d2", m_d2, 8);

    // PS8: overwrite pending within a period, then strobe on the PS edge.
    repeat (20) tick1();                       // k=20
    strobe(7'd100, 7'd0);                      // k=21
    repeat (19) tick1();                       // k=40
    strobe(7'd20, 7'd0);                       // k=41
    chk("act_hold_mid", dut.r_act1, 1);
    chk("pend_overwrite", dut.r_pend1, 20);
    repeat (470) tick1();                      // k=511
    chk("k511_trig", sample_trig, 0);
    duty_vld = 1'b1;
    D1       = 7'd90;
    tick1();                                   // PS9
    duty_vld = 1'b0;
    chk("ps9_trig", sample_trig, 1);
    chk("ps9_act", dut.r_act1, 20);
    chk("ps9_pend", dut.r_pend1, 90);
    measure(m_h1, m_d1, m_h2, m_d2, m_r1, m_r2, m_ov);
    chk("p9_h1", m_h1, 72);
    chk("p9_d1", m_d1, 16);
    chk("p9_r1", m_r1, 9);
    chk("ps10_stale", stale, 0);
    measure(m_h1, m_d1, m_h2, m_d2, m_r1, m_r2, m_ov);
    chk("p10_h1", m_h1, 352);
    chk("ps11_stale", stale, 1);

    // Reset mid-period while leg 1 high side is on.
    repeat (160) tick1();                      // k=160, cnt=40
    chk("pre_rst_cnt", cnt, 40);
    chk("pre_rst_s1h", s1_h, 1);
    reset = 1'b1;
    tick1();
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_trig", sample_trig, 0);
    chk("mid_rst_gates", {s1_h, s1_l, s2_h, s2_l}, 0);
    chk("mid_rst_stale", stale, 0);
    chk("mid_rst_act", dut.r_act1, 0);
    chk("mid_rst_pend", dut.r_pend1, 0);
    chk("mid_rst_state", dut.u_leg1.r_state, DEAD_TO_L);

    // Restart after reset, then disable mid-period.
    reset = 1'b0;
    tick1();                                   // PS, k=0
    chk("rs_trig", sample_trig, 1);
    chk("rs_stale", stale, 0);
    repeat (20) tick1();                       // k=20
    chk("rs_cnt", cnt, 5);
    chk("rs_s1l", s1_l, 1);
    enable = 1'b0;
    tick1();
    chk("dis_cnt", cnt, 0);
    chk("dis_trig", sample_trig, 0);
    chk("dis_gates", {s1_h, s1_l, s2_h, s2_l}, 0);
    chk("dis_state", dut.u_leg2.r_state, DEAD_TO_L);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpwm_fc.md
DPWM_FC -- requirements
Module: dpwm_fc

Interface
REQ-001 Parameter PRESC, default 4, clock cycles per carrier count; legal range 1..255.
REQ-002 Parameter DT, default 8, dead time in clock cycles per transition; legal range 1..255.
REQ-003 clock  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  1 = modulator running; 0 = gates off, carrier held.
REQ-006 duty_vld  in  1  one-cycle strobe; D1/D2 valid (driven by the control core's done_port).
REQ-007 D1  in  7  leg-1 duty code, 0..127, in units of 1/128.
REQ-008 D2  in  7  leg-2 duty code, 0..127, in units of 1/128.
REQ-009 sample_trig  out  1  one-cycle pulse at each period start; drives the control core's start_port.
REQ-010 s1_h, s1_l  out  1 each  leg-1 high-side and low-side gate commands.
REQ-011 s2_h, s2_l  out  1 each  leg-2 high-side and low-side gate commands.
REQ-012 cnt  out  7  current carrier count.
REQ-013 stale  out  1  previous period ran without a fresh duty update.

Function
REQ-014 The prescaler shall count 0..PRESC-1 while enable=1; tick = (prescaler == PRESC-1).
- On tick, cnt shall increment modulo 128.
- Period length = 128*PRESC clocks (512 at default).
REQ-015 Period start (PS) shall be the first cycle with cnt=0 and prescaler=0 while enable=1, including the first cycle after enable rises.
- sample_trig = 1 exactly in PS cycles.
REQ-016 On duty_vld, D1 and D2 shall be captured into pending registers; a later strobe overwrites an earlier one within the same period.
REQ-017 Active duty registers shall load from pending only at the clock edge that enters a PS cycle.
- If duty_vld coincides with that edge, active takes the old pending value; the new value applies one period later.
REQ-018 raw1 = (cnt < act1); raw2 = (((cnt+64) mod 128) < act2), giving a 180-degree interleave.
- Code 0 gives raw always 0; code 127 gives raw high for 127/128 of the period.
REQ-019 Each leg shall run a registered 4-state machine: L_ON, DEAD_TO_H, H_ON, DEAD_TO_L.
- L_ON with raw=1 -> DEAD_TO_H; H_ON with raw=0 -> DEAD_TO_L.
- In a DEAD state both gates are 0 for DT cycles, then the state enters the target ON state.
- If raw reverses during DEAD, the state switches to the opposite DEAD state and the dead counter restarts.
- A pulse shorter than DT is swallowed.
REQ-020 Gate outputs shall be registered.
- s_x_h = 1 only in H_ON; s_x_l = 1 only in L_ON.
- s_x_h and s_x_l shall never be 1 in the same cycle.
REQ-021 enable=0 shall have the following effect at the next edge:
- all gates 0, both FSMs in DEAD_TO_L with the dead counter cleared;
- prescaler=0, cnt=0, sample_trig=0;
- pending/active registers and stale hold their values.
REQ-022 At each PS, stale shall be set to 1 if no duty_vld occurred since the previous PS, otherwise cleared to 0.
- The first PS after enable or reset shall not set stale.

Reset
REQ-023 reset shall force, at the next edge:
- cnt=0, prescaler=0, sample_trig=0, stale=0;
- pending and active duty = 0;
- all four gates 0, both FSMs in DEAD_TO_L with the dead counter cleared.
REQ-024 reset shall override enable and duty_vld, and shall take effect mid-period or mid-dead-time.

Structure
REQ-025 A shared package shall hold CNT_W=7, HALF_OFFSET=64, and the leg-state enum.
REQ-026 The dead-time FSM shall be a sub-module dt_leg (ports: clock, reset, enable, raw, gate_h, gate_l, parameter DT), instantiated once per leg.

Verification
REQ-027 Reset, then enable=1 with no duty -> sample_trig at enable+0 and every 512 clocks; s1_l rises 8 clocks after enable; s1_h stays 0; stale=1 from the second PS.
REQ-028 duty_vld with D1=64 -> from the next PS, raw1 high 256 clocks; s1_h high 248 clocks; both gates 0 for 8 clocks at each edge.
REQ-029 D1=D2=64 -> leg-2 high interval starts 256 clocks after leg 1's; s1_h and s2_h never overlap.
REQ-030 D1=1 -> raw1 high 4 clocks; s1_h never asserts; s1_l low for 12 consecutive clocks.
REQ-031 Strobes D1=100 then D1=20 in the same period, then a strobe on the PS edge with D1=90 -> active stays at the old value mid-period; 20 applies next period; 90 applies the period after.
REQ-032 reset asserted at cnt=40 with s1_h=1 -> next edge all outputs 0, cnt=0; a bench assertion checks gate mutual exclusion throughout all scenarios.
